// File: rtl/data_bus_arb_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package data_bus_arb_pkg;

    localparam int NumMasters = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef logic master_id_t;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

    // Width of the hold counter; it must hold MaxHold-1 and never be zero bits wide.
    function automatic int hold_width(input int max_hold);
        if (max_hold < 1) begin
            return 1;
        end else begin
            return $clog2(max_hold + 1);
        end
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rd_tag_pipe.sv
// Read-tag shift register: remembers which master issued each read so the
// synchronous read data can be steered back ReadLatency cycles later.
module rd_tag_pipe
    import data_bus_arb_pkg::*;
#(
    parameter int ReadLatency = 1
) (
    input  logic    clk,
    input  logic    clear,
    input  rd_tag_t push_tag,
    output rd_tag_t tail_tag
);

    rd_tag_t pipe_r [ReadLatency];

    // Shift one tag per cycle; a clear drops every read still in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= push_tag;
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tail_tag = pipe_r[ReadLatency-1];

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin data bus arbiter with bounded ownership hold time
// and tagged routing of synchronous read data back to the issuing master.
module data_bus_arbiter
    import data_bus_arb_pkg::*;
#(
    parameter int AddrWidth   = 30,
    parameter int DataWidth   = 32,
    parameter int ReadLatency = 1,
    parameter int MaxHold     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req_i,
    input  logic [AddrWidth-1:0] m0_addr_i,
    input  logic [DataWidth-1:0] m0_wdata_i,
    input  logic                 m0_wr_i,
    input  logic [3:0]           m0_byte_en_i,
    output logic                 m0_gnt_o,
    output logic [DataWidth-1:0] m0_rdata_o,
    output logic                 m0_rvalid_o,
    input  logic                 m1_req_i,
    input  logic [AddrWidth-1:0] m1_addr_i,
    input  logic [DataWidth-1:0] m1_wdata_i,
    input  logic                 m1_wr_i,
    input  logic [3:0]           m1_byte_en_i,
    output logic                 m1_gnt_o,
    output logic [DataWidth-1:0] m1_rdata_o,
    output logic                 m1_rvalid_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic                 wr_o,
    output logic                 addr_strobe_o,
    output logic [3:0]           byte_en_o,
    input  logic [DataWidth-1:0] rdata_i
);

    localparam int                HoldW    = hold_width(MaxHold);
    localparam logic [HoldW-1:0]  HoldLast = (MaxHold == 0) ? '0 : HoldW'(MaxHold - 1);

    arb_state_e       state_r;
    arb_state_e       state_next_s;
    master_id_t       last_owner_r;
    logic [HoldW-1:0] hold_cnt_r;
    logic             issue0_s;
    logic             issue1_s;
    logic             hold_limit_s;
    rd_tag_t          push_tag_s;
    rd_tag_t          tail_tag_s;

    assign issue0_s     = (state_r == OWN0) && m0_req_i;
    assign issue1_s     = (state_r == OWN1) && m1_req_i;
    assign hold_limit_s = (MaxHold != 0) && (hold_cnt_r == HoldLast);

    // Next-owner decision: round-robin from IDLE, forced handover at the hold limit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (m0_req_i && m1_req_i) begin
                    state_next_s = (last_owner_r == 1'b1) ? OWN0 : OWN1;
                end else if (m0_req_i) begin
                    state_next_s = OWN0;
                end else if (m1_req_i) begin
                    state_next_s = OWN1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN0: begin
                if (!m0_req_i) begin
                    state_next_s = m1_req_i ? OWN1 : IDLE;
                end else if (m1_req_i && hold_limit_s) begin
                    state_next_s = OWN1;
                end else begin
                    state_next_s = OWN0;
                end
            end
            OWN1: begin
                if (!m1_req_i) begin
                    state_next_s = m0_req_i ? OWN0 : IDLE;
                end else if (m0_req_i && hold_limit_s) begin
                    state_next_s = OWN0;
                end else begin
                    state_next_s = OWN1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Ownership state, round-robin history and beat counter for the current owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_owner_r <= master_id_t'(NumMasters - 1);
            hold_cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                hold_cnt_r <= '0;
                if (state_next_s == OWN0) begin
                    last_owner_r <= 1'b0;
                end else if (state_next_s == OWN1) begin
                    last_owner_r <= 1'b1;
                end else begin
                    last_owner_r <= last_owner_r;
                end
            end else if ((issue0_s || issue1_s) && (MaxHold != 0) && (hold_cnt_r != HoldLast)) begin
                hold_cnt_r <= hold_cnt_r + HoldW'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // Bus mux: only an issuing owner may drive the bus; everything else reads as zero.
    always_comb begin
        addr_o        = '0;
        wdata_o       = '0;
        wr_o          = 1'b0;
        addr_strobe_o = 1'b0;
        byte_en_o     = 4'b0000;
        push_tag_s    = '0;
        if (issue0_s) begin
            addr_o           = m0_addr_i;
            wdata_o          = m0_wdata_i;
            wr_o             = m0_wr_i;
            addr_strobe_o    = 1'b1;
            byte_en_o        = m0_byte_en_i;
            push_tag_s.valid = !m0_wr_i;
            push_tag_s.id    = 1'b0;
        end else if (issue1_s) begin
            addr_o           = m1_addr_i;
            wdata_o          = m1_wdata_i;
            wr_o             = m1_wr_i;
            addr_strobe_o    = 1'b1;
            byte_en_o        = m1_byte_en_i;
            push_tag_s.valid = !m1_wr_i;
            push_tag_s.id    = 1'b1;
        end else begin
            push_tag_s = '0;
        end
    end

    rd_tag_pipe #(
        .ReadLatency(ReadLatency)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .clear   (!rst_n),
        .push_tag(push_tag_s),
        .tail_tag(tail_tag_s)
    );

    assign m0_gnt_o    = (state_r == OWN0);
    assign m1_gnt_o    = (state_r == OWN1);
    assign m0_rvalid_o = tail_tag_s.valid && (tail_tag_s.id == 1'b0);
    assign m1_rvalid_o = tail_tag_s.valid && (tail_tag_s.id == 1'b1);
    assign m0_rdata_o  = m0_rvalid_o ? rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_i : '0;

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-master arbiter for the shared data bus that feeds the address decoder, dual-port RAM data port and UART register port.
- Master 0 is the CPU data port. Master 1 is a secondary bus master, such as the DMA or the UART boot loader.
- Grants bus ownership round-robin with a bounded hold time.
- Routes synchronous read data back to the master that issued each read, using a read-tag pipeline.

Parameters:
- AddrWidth, 30, word address width.
- DataWidth, 32, data width.
- ReadLatency, 1, cycles from a read issue to valid rdata_i; legal range 1..4.
- MaxHold, 16, maximum issued beats per ownership while the other master waits; 0 means unlimited.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m0_req_i  in  1  master 0 wants the bus this cycle
- m0_addr_i  in  AddrWidth  master 0 word address
- m0_wdata_i  in  DataWidth  master 0 write data
- m0_wr_i  in  1  master 0 write (1) / read (0)
- m0_byte_en_i  in  4  master 0 byte enables
- m0_gnt_o  out  1  master 0 owns the bus
- m0_rdata_o  out  DataWidth  read data to master 0
- m0_rvalid_o  out  1  m0_rdata_o valid
- m1_req_i, m1_addr_i, m1_wdata_i, m1_wr_i, m1_byte_en_i, m1_gnt_o, m1_rdata_o, m1_rvalid_o  same widths and meanings as master 0, for master 1
- addr_o  out  AddrWidth  bus address
- wdata_o  out  DataWidth  bus write data
- wr_o  out  1  bus write strobe
- addr_strobe_o  out  1  bus access valid
- byte_en_o  out  4  bus byte enables
- rdata_i  in  DataWidth  bus read data (muxed RAM/IO)

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values (rst_n low at a clk edge):
  - state=IDLE, last_owner=1 so master 0 wins first, hold_cnt=0, tag pipe cleared.
  - All outputs are 0 from the following cycle.
  - Reset mid-transaction discards in-flight reads; no rvalid is produced for them.
- States IDLE, OWN0, OWN1, all registered.
- mX_gnt_o is decoded from state only; no combinational path from req to gnt.
- Issue: master X issues in a cycle when state==OWNX and mX_req_i=1.
  - Bus outputs then take master X's addr, wdata, wr and byte_en.
  - addr_strobe_o=1.
  - wr_o=mX_wr_i.
- Otherwise all bus outputs are 0. In particular, wr_o and addr_strobe_o are never high without a grant.
- IDLE transitions:
  - Only one master requesting: go to that master's OWN state.
  - Both requesting: go to the master that is not last_owner.
  - Grant latency from IDLE is 1 cycle.
- OWNX transitions:
  - mX_req_i=0: go to OWN(other) if the other master is requesting, else IDLE.
  - mX_req_i=1 and other requesting and MaxHold!=0 and hold_cnt==MaxHold-1: go to OWN(other). This forced handover happens after exactly MaxHold issued beats.
  - Otherwise stay in OWNX.
- last_owner is updated on every entry to an OWN state.
- hold_cnt:
  - Cleared on any state change.
  - Incremented on each issue.
  - Saturates at MaxHold-1; width $clog2(MaxHold+1), minimum 1.
- Handover OWN0->OWN1 costs no idle cycle. The new owner can issue in the first cycle after the transition edge.
- Read return:
  - Each issued read (wr=0) pushes {valid=1, id=X} into a ReadLatency-deep tag shift register. Writes and idle cycles push valid=0.
  - mX_rvalid_o = tail.valid && tail.id==X.
  - mX_rdata_o = rdata_i when mX_rvalid_o, else 0.
  - Reads in flight across a handover still return to their issuer.
- Simultaneous requests when both masters raise req in the same IDLE cycle: round-robin as above; no master starves.

Decomposition:
- Package data_bus_arb_pkg holds:
  - arb_state_e {IDLE, OWN0, OWN1}
  - master_id_t (1 bit)
  - rd_tag_t struct {valid, id}
  - constant NumMasters=2
- Sub-module rd_tag_pipe: parameterised ReadLatency shift register of rd_tag_t with synchronous clear. The arbiter FSM and output muxing stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while both reqs are 1 -> all outputs 0. First grant is to m0, 1 cycle after rst_n rises.
- Single master 0 read at addr 0x0000010: m0_gnt_o next cycle, then addr_strobe_o=1, addr_o=0x10, wr_o=0. m0_rvalid_o=1 exactly ReadLatency cycles later with rdata_i=0xDEADBEEF; m1_rvalid_o stays 0.
- MaxHold=4 fairness: m0 streams writes continuously and m1 requests from cycle 2 -> exactly 4 m0 issues, then m1_gnt_o with no idle cycle. Grant returns to m0 when m1 drops req.
- Read across handover: m0 read issued in the last cycle of its ownership, m1 write on the next cycle -> rvalid goes to m0 only. No bus strobe or wr_o occurs on a non-granted master's request.
- Reset mid-operation: rst_n=0 in the cycle after a read issue -> no rvalid afterwards, state IDLE, bus outputs 0.
- Both masters request simultaneously from IDLE after m1 was last owner -> m0 granted. On the next contention from IDLE, m1 is granted.
